// File: rtl/step_controller.sv
// Single-step / free-run enable generator for a teaching CPU: debounces a
// pushbutton into one-cycle enable pulses, with a lockout after release.
module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50_000,
  parameter int unsigned HOLDOFF_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_mode,
  input  logic       key_n,
  input  logic       halt,
  output logic       en,
  output logic [7:0] step_cnt,
  output logic [2:0] state_dbg
);

  localparam int unsigned CNT_MAX = ((DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ?
                                     DEBOUNCE_CYCLES : HOLDOFF_CYCLES) - 1;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_PULSE    = 3'd2;
  localparam logic [2:0] S_RELEASE  = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;
  localparam logic [2:0] S_RUN      = 3'd5;

  logic             key_meta;
  logic             key_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             en_nxt;

  // Two-flop synchronizer; idles high so reset looks like a released key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

  // Next-state, shared counter and enable decode
  always_comb begin
    state_nxt = S_IDLE;
    cnt_nxt   = '0;
    en_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!key_s) state_nxt = S_DEBOUNCE;
        else        state_nxt = S_IDLE;
      end
      S_DEBOUNCE: begin
        if (key_s)             state_nxt = S_IDLE;
        else if (cnt == DEB_LAST) state_nxt = S_PULSE;
        else                   state_nxt = S_DEBOUNCE;
      end
      S_PULSE:   state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (key_s) state_nxt = S_HOLDOFF;
        else       state_nxt = S_RELEASE;
      end
      S_HOLDOFF: begin
        if (cnt == HOLD_LAST) state_nxt = S_IDLE;
        else                  state_nxt = S_HOLDOFF;
      end
      S_RUN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Mode select overrides the stepping sequence from any state
    if (!step_mode) state_nxt = S_RUN;

    // Counter restarts on every transition so each state times from zero
    if (state_nxt == state) begin
      if ((state == S_DEBOUNCE && !key_s) || state == S_HOLDOFF) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else begin
        cnt_nxt = cnt;
      end
    end

    en_nxt = ((state_nxt == S_PULSE) || (state_nxt == S_RUN)) && !halt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      en       <= 1'b0;
      step_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      en    <= en_nxt;
      if (en) step_cnt <= step_cnt + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with short debounce/hold-off timings.
module tb_step_controller;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 8;

  logic       clk;
  logic       rst;
  logic       step_mode;
  logic       key_n;
  logic       halt;
  logic       en;
  logic [7:0] step_cnt;
  logic [2:0] state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .step_mode(step_mode),
    .key_n    (key_n),
    .halt     (halt),
    .en       (en),
    .step_cnt (step_cnt),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b0; step_mode = 1'b1; halt = 1'b0; key_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_mode = 1'($urandom); key_n = 1'($urandom); halt = 1'($urandom);
    #1 rst = 1'b0;
    #2;
    n_total++; if (en !== 1'b0) $display("FAIL reset_en: got %b want 0", en); else n_pass++;
    n_total++; if (step_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", step_cnt); else n_pass++;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
    @(negedge clk);
    rst = 1'b1; step_mode = 1'b0; halt = 1'b0; key_n = 1'b1;
    repeat (10) @(negedge clk);
    n_total++; if (state_dbg !== 3'd5) $display("FAIL reset_prerun_state: got %0d want 5", state_dbg); else n_pass++;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_total++; if (en !== 1'b0) $display("FAIL reset_async_en: got %b want 0", en); else n_pass++;
    n_total++; if (step_cnt !== 8'd0) $display("FAIL reset_async_cnt: got %0d want 0", step_cnt); else n_pass++;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL reset_async_state: got %0d want 0", state_dbg); else n_pass++;
  endtask

  task automatic test_clean_press();
    logic [2:0] exp_st;
    logic       exp_en;
    logic [7:0] exp_cnt;
    apply_reset();
    key_n = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k <= 2)       exp_st = 3'd0;
      else if (k <= 6)  exp_st = 3'd1;
      else if (k == 7)  exp_st = 3'd2;
      else if (k <= 22) exp_st = 3'd3;
      else if (k <= 30) exp_st = 3'd4;
      else              exp_st = 3'd0;
      exp_en  = (k == 7);
      exp_cnt = (k >= 8) ? 8'd1 : 8'd0;
      n_total++; if (state_dbg !== exp_st) $display("FAIL press_state k=%0d: got %0d want %0d", k, state_dbg, exp_st); else n_pass++;
      n_total++; if (en !== exp_en) $display("FAIL press_en k=%0d: got %b want %b", k, en, exp_en); else n_pass++;
      n_total++; if (step_cnt !== exp_cnt) $display("FAIL press_cnt k=%0d: got %0d want %0d", k, step_cnt, exp_cnt); else n_pass++;
      if (k == 20) key_n = 1'b1;
    end
  endtask

  task automatic test_bounce();
    logic [2:0] exp_st [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd1, 3'd1,
                                3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    apply_reset();
    key_n = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      n_total++; if (en !== 1'b0) $display("FAIL bounce_en k=%0d: got %b want 0", k, en); else n_pass++;
      n_total++; if (state_dbg !== exp_st[k-1]) $display("FAIL bounce_state k=%0d: got %0d want %0d", k, state_dbg, exp_st[k-1]); else n_pass++;
      if (k == 2) key_n = 1'b1;
      if (k == 3) key_n = 1'b0;
      if (k == 6) key_n = 1'b1;
    end
    n_total++; if (step_cnt !== 8'd0) $display("FAIL bounce_cnt: got %0d want 0", step_cnt); else n_pass++;
  endtask

  task automatic test_holdoff_press();
    apply_reset();
    key_n = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      n_total++; if (en !== (k == 7)) $display("FAIL holdoff_en k=%0d: got %b want %b", k, en, (k == 7)); else n_pass++;
      if (k == 18 || k == 20) begin
        n_total++; if (state_dbg !== 3'd4) $display("FAIL holdoff_state k=%0d: got %0d want 4", k, state_dbg); else n_pass++;
      end
      if (k == 21) begin
        n_total++; if (state_dbg !== 3'd0) $display("FAIL holdoff_exit k=%0d: got %0d want 0", k, state_dbg); else n_pass++;
      end
      if (k == 10) key_n = 1'b1;
      if (k == 14) key_n = 1'b0;
      if (k == 17) key_n = 1'b1;
    end
    n_total++; if (step_cnt !== 8'd1) $display("FAIL holdoff_cnt: got %0d want 1", step_cnt); else n_pass++;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL holdoff_final_state: got %0d want 0", state_dbg); else n_pass++;
  endtask

  task automatic test_halt_drops_step();
    apply_reset();
    key_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_total++; if (en !== 1'b0) $display("FAIL halt_step_en k=%0d: got %b want 0", k, en); else n_pass++;
      if (k == 7) begin
        n_total++; if (state_dbg !== 3'd2) $display("FAIL halt_step_pulse: got %0d want 2", state_dbg); else n_pass++;
      end
      if (k == 8) begin
        n_total++; if (state_dbg !== 3'd3) $display("FAIL halt_step_release: got %0d want 3", state_dbg); else n_pass++;
      end
      if (k == 6) halt = 1'b1;
      if (k == 7) halt = 1'b0;
    end
    n_total++; if (step_cnt !== 8'd0) $display("FAIL halt_step_cnt: got %0d want 0", step_cnt); else n_pass++;
  endtask

  task automatic test_free_run_halt();
    logic       exp_en;
    logic [7:0] exp_cnt;
    logic       seen_zero;
    apply_reset();
    step_mode = 1'b0;
    exp_en = 1'b0; exp_cnt = 8'd0; seen_zero = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      exp_cnt = 8'(exp_cnt + {7'd0, exp_en});
      exp_en  = !halt;
      if (k > 1 && step_cnt == 8'd0) seen_zero = 1'b1;
      n_total++; if (en !== exp_en) $display("FAIL run_en k=%0d: got %b want %b", k, en, exp_en); else n_pass++;
      n_total++; if (step_cnt !== exp_cnt) $display("FAIL run_cnt k=%0d: got %0d want %0d", k, step_cnt, exp_cnt); else n_pass++;
      n_total++; if (state_dbg !== 3'd5) $display("FAIL run_state k=%0d: got %0d want 5", k, state_dbg); else n_pass++;
      if (k == 100) halt = 1'b1;
      if (k == 105) halt = 1'b0;
    end
    n_total++; if (step_cnt !== 8'd38) $display("FAIL run_final_cnt: got %0d want 38", step_cnt); else n_pass++;
    n_total++; if (seen_zero !== 1'b1) $display("FAIL run_wrap: got %b want 1", seen_zero); else n_pass++;
  endtask

  task automatic test_mode_switch();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3};
    logic       exp_en [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    key_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (state_dbg !== 3'd5) $display("FAIL switch_pre_state: got %0d want 5", state_dbg); else n_pass++;
    n_total++; if (en !== 1'b1) $display("FAIL switch_pre_en: got %b want 1", en); else n_pass++;
    step_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_total++; if (state_dbg !== exp_st[k]) $display("FAIL switch_state k=%0d: got %0d want %0d", k, state_dbg, exp_st[k]); else n_pass++;
      n_total++; if (en !== exp_en[k]) $display("FAIL switch_en k=%0d: got %b want %b", k, en, exp_en[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    apply_reset();
    key_n = 1'b0;
    repeat (5) @(negedge clk);
    n_total++; if (state_dbg !== 3'd1) $display("FAIL middeb_pre_state: got %0d want 1", state_dbg); else n_pass++;
    rst = 1'b0; key_n = 1'b1;
    #1;
    n_total++; if (state_dbg !== 3'd0) $display("FAIL middeb_async_state: got %0d want 0", state_dbg); else n_pass++;
    n_total++; if (en !== 1'b0) $display("FAIL middeb_async_en: got %b want 0", en); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      n_total++; if (en !== 1'b0) $display("FAIL middeb_en k=%0d: got %b want 0", k, en); else n_pass++;
      n_total++; if (state_dbg !== 3'd0) $display("FAIL middeb_state k=%0d: got %0d want 0", k, state_dbg); else n_pass++;
    end
    n_total++; if (step_cnt !== 8'd0) $display("FAIL middeb_cnt: got %0d want 0", step_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_holdoff_press();
    test_halt_drops_step();
    test_free_run_halt();
    test_mode_switch();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50_000, is the number of cycles key_n must stay low before a step is issued.
REQ-002 Parameter HOLDOFF_CYCLES, default 5_000_000, is the number of cycles of lockout after key release.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 step_mode  input  1  1 = single-step, 0 = free-run.
REQ-006 key_n  input  1  raw pushbutton, active-low, asynchronous, may bounce.
REQ-007 halt  input  1  synchronous, 1 = suppress all enables.
REQ-008 en  output  1  registered enable to the program counter and register file.
REQ-009 step_cnt  output  8  count of cycles with en=1, wraps modulo 256.
REQ-010 state_dbg  output  3  current FSM state encoding, for the hex display.

Function
REQ-011 key_n SHALL pass through a two-flop synchronizer whose flops reset to 1; key_s is its output, and only key_s is used internally.
REQ-012 FSM states and encodings SHALL be: IDLE=0, DEBOUNCE=1, PULSE=2, RELEASE=3, HOLDOFF=4, RUN=5; encodings 6 and 7 SHALL go to IDLE.
REQ-013 One shared counter SHALL be sized to hold max(DEBOUNCE_CYCLES, HOLDOFF_CYCLES)-1.
REQ-014 The counter SHALL clear on every state change.
REQ-015 From any state, step_mode=0 SHALL force next state RUN.
REQ-016 In RUN, step_mode=1 SHALL force next state IDLE.
REQ-017 IDLE: key_s=0 -> DEBOUNCE; otherwise stay in IDLE.
REQ-018 DEBOUNCE: the counter increments while key_s=0.
REQ-019 DEBOUNCE: key_s=1 -> IDLE, which discards a bounce.
REQ-020 DEBOUNCE: counter==DEBOUNCE_CYCLES-1 with key_s=0 -> PULSE.
REQ-021 PULSE SHALL last exactly one cycle, then go to RELEASE unconditionally.
REQ-022 RELEASE: stay until key_s=1, then go to HOLDOFF.
REQ-023 HOLDOFF: the counter increments, and key_s is ignored.
REQ-024 HOLDOFF: counter==HOLDOFF_CYCLES-1 -> IDLE.
REQ-025 en SHALL be a flop; its next value is 1 when (next state==PULSE or next state==RUN) and halt=0, and 0 otherwise.
REQ-026 Single-step latency: en SHALL first be 1 after the (DEBOUNCE_CYCLES+3)th rising edge counted from the first edge that samples key_n low, provided key_n is held low.
REQ-027 One key press, however long it is held, SHALL produce exactly one en pulse.
REQ-028 halt=1 on the cycle that enters PULSE SHALL drop that step: en stays 0 and the FSM still proceeds to RELEASE.
REQ-029 In RUN, en SHALL be 0 on the edge after halt rises.
REQ-030 In RUN, en SHALL be 1 again on the edge after halt falls.
REQ-031 step_cnt SHALL increment by 1 on every edge where en=1, and wrap from 255 to 0.
REQ-032 Switching step_mode from 0 to 1 in the same cycle that key_s=0 SHALL enter IDLE first; the press is then handled from IDLE on the next edge.

Reset
REQ-033 While rst=0, the block SHALL hold asynchronously: en=0, step_cnt=0, state=IDLE, state_dbg=0, counter=0, synchronizer flops=1.
REQ-034 After rst rises, the first state change SHALL occur on the next clk rising edge.
REQ-035 Reset mid-operation SHALL abort any debounce, pulse or hold-off with no en pulse.

Verification (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-036 Reset: rst=0 with random inputs -> en=0, step_cnt=0, state_dbg=0 immediately, with no clock edge needed.
REQ-037 Clean press: step_mode=1, key_n low for 20 cycles then high -> exactly one en pulse after edge 7, step_cnt=1, state_dbg sequence 0,1,2,3,4,0, HOLDOFF lasting 8 cycles.
REQ-038 Bounce: key_n low 2 cycles, high 1, low 3, high -> en never 1, step_cnt=0, state_dbg returns to 0.
REQ-039 Press during HOLDOFF: second press of 3 cycles inside the 8-cycle lockout -> no en, step_cnt unchanged.
REQ-040 Free-run with halt: step_mode=0 for 300 cycles with halt pulsed high for 5 cycles -> en=1 every cycle except the 5 halted cycles (shifted by one), step_cnt wraps through 0, state_dbg=5.
REQ-041 Reset mid-DEBOUNCE: rst=0 asserted at counter=2 -> en stays 0, state_dbg=0 asynchronously, no pulse after rst is released while key_n stays high.
